// File: rtl/tdc_spi_arbiter.sv
// tdc_spi_arbiter: lends one SPI byte engine to N_CH tdc_control channels.
// Ownership is granted per chip-select frame and rotates round-robin. A
// silent owner is forcibly released after FRAME_TIMEOUT idle cycles.
module tdc_spi_arbiter #(
  parameter int N_CH          = 4,
  parameter int FRAME_TIMEOUT = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     req_start,
  input  logic [8*N_CH-1:0]   req_mosi,
  input  logic [N_CH-1:0]     req_cs_end,
  output logic [N_CH-1:0]     req_busy,
  output logic [7:0]          req_miso,
  output logic [N_CH-1:0]     req_new_data,
  output logic                spi_start,
  output logic [7:0]          spi_mosi,
  output logic                spi_cs_end,
  input  logic                spi_busy,
  input  logic                spi_new_data,
  input  logic [7:0]          spi_miso,
  output logic [N_CH-1:0]     grant,
  output logic                timeout_err
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(FRAME_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, XFER, GAP} state_t;

  state_t                 state;
  logic [N_CH-1:0]        pend;
  logic [N_CH-1:0][7:0]   hold_mosi;
  logic [N_CH-1:0]        hold_cs_end;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       ptr;
  logic                   byte_in_flight;
  logic [CNT_W-1:0]       tcnt;

  logic [N_CH-1:0]        capture;
  logic [N_CH-1:0]        pend_next;
  logic [IDX_W-1:0]       sel;
  logic                   any_pend;
  logic [IDX_W-1:0]       ptr_after;

  // A start from any channel other than the owner is queued; the owner's
  // own starts are handled by the FSM (GAP) or ignored (LAUNCH/XFER).
  assign capture   = req_start & ~pend & ~grant;
  assign pend_next = pend | capture;
  assign req_busy  = pend | (byte_in_flight ? grant : '0);
  assign ptr_after = (owner == IDX_W'(N_CH - 1)) ? '0 : owner + 1'b1;

  // Round-robin pick: first pending channel at or after ptr, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    int j;
    sel      = '0;
    any_pend = 1'b0;
    j        = 0;
    for (int k = 0; k < N_CH; k++) begin
      j = int'(ptr) + k;
      if (j >= N_CH) j = j - N_CH;
      if (!any_pend && pend_next[j]) begin
        any_pend = 1'b1;
        sel      = IDX_W'(j);
      end
    end
  end

  // Frame FSM with request capture, SPI launch and completion routing.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below reads the pre-edge values of all registers.
    if (!rst) begin
      // NOTE: the small per-channel holding registers are cleared with the
      // rest of the state so a reset never replays a stale byte.
      state          <= IDLE;
      pend           <= '0;
      hold_mosi      <= '0;
      hold_cs_end    <= '0;
      owner          <= '0;
      ptr            <= '0;
      byte_in_flight <= 1'b0;
      tcnt           <= '0;
      grant          <= '0;
      spi_start      <= 1'b0;
      spi_mosi       <= '0;
      spi_cs_end     <= 1'b0;
      req_miso       <= '0;
      req_new_data   <= '0;
      timeout_err    <= 1'b0;
    end else begin
      spi_start    <= 1'b0;
      req_new_data <= '0;
      timeout_err  <= 1'b0;
      pend         <= pend_next;

      for (int i = 0; i < N_CH; i++) begin
        if (capture[i]) begin
          hold_mosi[i]   <= req_mosi[8*i +: 8];
          hold_cs_end[i] <= req_cs_end[i];
        end
      end

      case (state)
        IDLE: begin
          if (any_pend) begin
            owner <= sel;
            grant <= N_CH'(1) << sel;
            state <= LAUNCH;
          end
        end

        LAUNCH: begin
          spi_mosi   <= hold_mosi[owner];
          spi_cs_end <= hold_cs_end[owner];
          // Hold off while the engine is still busy with anything else.
          if (!spi_busy) begin
            spi_start      <= 1'b1;
            pend           <= pend_next & ~grant;
            byte_in_flight <= 1'b1;
            state          <= XFER;
          end
        end

        XFER: begin
          if (spi_new_data) begin
            req_miso       <= spi_miso;
            req_new_data   <= grant;
            byte_in_flight <= 1'b0;
            if (spi_cs_end) begin
              grant <= '0;
              ptr   <= ptr_after;
              state <= IDLE;
            end else begin
              tcnt  <= '0;
              state <= GAP;
            end
          end
        end

        GAP: begin
          if (req_start[owner]) begin
            hold_mosi[owner]   <= req_mosi[8*owner +: 8];
            hold_cs_end[owner] <= req_cs_end[owner];
            state              <= LAUNCH;
          end else if (tcnt == CNT_W'(FRAME_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            grant       <= '0;
            ptr         <= ptr_after;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
